// File: rtl/apu_bus_writer.sv
// ============================================================================
// Module   : apu_bus_writer
// Brief    : Replays register-write commands as 6502-style write cycles into
//            the APU window $4000-$401F, with a self-generated M2 phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apu_bus_writer #(
   parameter int DIV    = 12,
   parameter int M2_LO  = 5,
   parameter int WAIT_W = 16
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [4:0]        cmd_addr,
   input  logic [7:0]        cmd_data,
   input  logic [WAIT_W-1:0] cmd_wait,
   output logic [15:0]       A,
   output logic [7:0]        D_out,
   output logic              D_oe,
   output logic              RnW,
   output logic              M2,
   output logic              busy,
   output logic              wr_done
);

   localparam int              c_PH_W    = $clog2(DIV);
   localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(DIV - 1);
   localparam logic [c_PH_W-1:0] c_M2_LO   = c_PH_W'(M2_LO);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_DELAY = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_PH_W-1:0]   r_ph;
   logic [c_PH_W-1:0]   w_ph_nxt;
   logic                w_bnd;
   logic                w_accept;
   logic                w_wr_start;
   logic                w_wr_end;
   logic                r_m2;
   logic                r_ready;
   logic                r_busy;
   logic                r_done;
   logic [15:0]         r_a;
   logic [7:0]          r_d;
   logic                r_oe;
   logic                r_rnw;
   logic [4:0]          r_addr;
   logic [7:0]          r_data;
   logic [WAIT_W-1:0]   r_cnt;

   // The CPU-cycle boundary is the edge that wraps ph back to zero.
   assign w_bnd    = (r_ph == c_PH_LAST);
   assign w_ph_nxt = w_bnd ? '0 : r_ph + 1'b1;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_ph <= '0;
         r_m2 <= 1'b0;
      end else begin
         r_ph <= w_ph_nxt;
         r_m2 <= (w_ph_nxt >= c_M2_LO);
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_wr_start  = 1'b0;
      w_wr_end    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && r_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (w_bnd) begin
               if (r_cnt == '0) begin
                  w_wr_start  = 1'b1;
                  w_state_nxt = ST_WRITE;
               end else begin
                  w_state_nxt = ST_DELAY;
               end
            end
         end
         ST_DELAY: begin
            if (w_bnd && (r_cnt == WAIT_W'(1))) begin
               w_wr_start  = 1'b1;
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (w_bnd) begin
               w_wr_end    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake and bus outputs are registered from the next state so they
   // change on the same edge as the state itself.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_a     <= 16'h0000;
         r_d     <= 8'h00;
         r_oe    <= 1'b0;
         r_rnw   <= 1'b1;
         r_addr  <= 5'h00;
         r_data  <= 8'h00;
         r_cnt   <= '0;
      end else begin
         r_ready <= (w_state_nxt == ST_IDLE);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= w_wr_end;
         if (w_accept) begin
            r_addr <= cmd_addr;
            r_data <= cmd_data;
            r_cnt  <= cmd_wait;
         end else if ((r_state == ST_DELAY) && w_bnd) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_wr_start) begin
            r_a   <= {8'h40, 3'b000, r_addr};
            r_d   <= r_data;
            r_oe  <= 1'b1;
            r_rnw <= 1'b0;
         end else if (w_wr_end) begin
            r_oe  <= 1'b0;
            r_rnw <= 1'b1;
         end
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign wr_done   = r_done;
   assign A         = r_a;
   assign D_out     = r_d;
   assign D_oe      = r_oe;
   assign RnW       = r_rnw;
   assign M2        = r_m2;

endmodule

`default_nettype wire

// File: tb/tb_apu_bus_writer.sv
// ============================================================================
// Module   : tb_apu_bus_writer
// Brief    : Self-checking bench; expected timing is derived from the edge
//            count since reset and the command's wait value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apu_bus_writer;

   localparam int DIV     = 12;
   localparam int M2_LO   = 5;
   localparam int WAIT_W  = 16;
   localparam int DIV2    = 4;
   localparam int M2_LO2  = 1;
   localparam int WAIT_W2 = 12;

   logic CLK = 1'b0;
   logic RES = 1'b1;
   always #5 CLK = ~CLK;

   logic              cmd_valid = 1'b0;
   logic [4:0]        cmd_addr  = '0;
   logic [7:0]        cmd_data  = '0;
   logic [WAIT_W-1:0] cmd_wait  = '0;
   logic              cmd_ready, D_oe, RnW, M2, busy, wr_done;
   logic [15:0]       A;
   logic [7:0]        D_out;

   logic               v2 = 1'b0;
   logic [4:0]         addr2 = '0;
   logic [7:0]         data2 = '0;
   logic [WAIT_W2-1:0] wait2 = '0;
   logic               ready2, oe2, rnw2, m2_2, busy2, done2;
   logic [15:0]        a2;
   logic [7:0]         dout2;

   apu_bus_writer #(.DIV(DIV), .M2_LO(M2_LO), .WAIT_W(WAIT_W)) u_dut (
      .CLK(CLK), .RES(RES), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_wait(cmd_wait),
      .A(A), .D_out(D_out), .D_oe(D_oe), .RnW(RnW), .M2(M2),
      .busy(busy), .wr_done(wr_done));

   apu_bus_writer #(.DIV(DIV2), .M2_LO(M2_LO2), .WAIT_W(WAIT_W2)) u_dut2 (
      .CLK(CLK), .RES(RES), .cmd_valid(v2), .cmd_ready(ready2),
      .cmd_addr(addr2), .cmd_data(data2), .cmd_wait(wait2),
      .A(a2), .D_out(dout2), .D_oe(oe2), .RnW(rnw2), .M2(m2_2),
      .busy(busy2), .wr_done(done2));

   int errors = 0;
   int checks = 0;
   int ecnt;   // CLK edges since reset release; ph is ecnt mod DIV

   always @(posedge CLK or posedge RES) begin
      if (RES) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   // Observation record of one command
   int          ob_ws, ob_wcnt, ob_done_e, ob_done_cnt;
   int          ob_oe_bad, ob_busy_bad, ob_ready_bad;
   logic        ob_ready_at_done;
   logic [15:0] ob_a;
   logic [7:0]  ob_d;

   // Reference: the write begins DIV*wait edges after the first boundary
   // strictly later than the accept edge.
   function automatic int exp_ws(input int ea, input int w, input int div);
      return (ea / div + 1) * div + w * div;
   endfunction

   task automatic send_cmd(input logic [4:0] a, input logic [7:0] d,
                           input logic [15:0] w, input int ph, output int ea);
      bit ok = 0;
      ea = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1 && (ph < 0 || (ecnt % DIV) == ph)) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_ready: cmd_ready never seen, got %b required 1", cmd_ready);
         return;
      end
      cmd_addr  = a;
      cmd_data  = d;
      cmd_wait  = w;
      cmd_valid = 1'b1;
      @(posedge CLK);
      #1;
      ea        = ecnt;
      cmd_valid = 1'b0;
      cmd_addr  = 5'($urandom);
      cmd_data  = 8'($urandom);
      cmd_wait  = 16'($urandom);
   endtask

   task automatic observe(input int limit);
      bit seen = 0;
      ob_ws = -1; ob_wcnt = 0; ob_done_e = -1; ob_done_cnt = 0;
      ob_oe_bad = 0; ob_busy_bad = 0; ob_ready_bad = 0;
      ob_ready_at_done = 1'b0; ob_a = '0; ob_d = '0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (RnW === 1'b0) begin
            if (ob_wcnt == 0) begin
               ob_ws = ecnt;
               ob_a  = A;
               ob_d  = D_out;
            end
            ob_wcnt++;
            if (D_oe !== 1'b1)      ob_oe_bad++;
            if (cmd_ready !== 1'b0) ob_ready_bad++;
         end else if (D_oe !== 1'b0) begin
            ob_oe_bad++;
         end
         if (wr_done === 1'b1) begin
            ob_done_cnt++;
            if (ob_done_e < 0) begin
               ob_done_e        = ecnt;
               ob_ready_at_done = cmd_ready;
            end
         end else if (!seen && busy !== 1'b1) begin
            ob_busy_bad++;
         end
         if (seen) break;
         if (wr_done === 1'b1) seen = 1;
      end
   endtask

   task automatic test_reset;
      int bad = 0;
      int bad2 = 0;
      int lows = 0;
      RES = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if ({A, D_out, D_oe, RnW, M2, cmd_ready, busy, wr_done} !==
          {16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: A=%h D=%h oe=%b rnw=%b m2=%b rdy=%b busy=%b done=%b required 0000 00 0 1 0 0 0 0",
                  A, D_out, D_oe, RnW, M2, cmd_ready, busy, wr_done);
      end
      RES = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
      end
      @(negedge CLK);
      checks++;
      if ({cmd_ready, RnW, D_oe, ready2} !== 4'b1101) begin
         errors++;
         $display("FAIL ready_after_release: rdy/rnw/oe/rdy2 got %b required 1101",
                  {cmd_ready, RnW, D_oe, ready2});
      end
      for (int i = 0; i < 3 * DIV; i++) begin
         if (i > 0) @(negedge CLK);
         if (M2 !== ((ecnt % DIV) >= M2_LO))     bad++;
         if (m2_2 !== ((ecnt % DIV2) >= M2_LO2)) bad2++;
         if (i < DIV && M2 === 1'b0)             lows++;
      end
      checks++;
      if (bad != 0 || bad2 != 0) begin
         errors++;
         $display("FAIL m2_pattern: wrong samples got %0d/%0d required 0/0", bad, bad2);
      end
      checks++;
      if (lows != M2_LO) begin
         errors++;
         $display("FAIL m2_low_count: got %0d required %0d", lows, M2_LO);
      end
   endtask

   task automatic test_single;
      int ea, ws;
      send_cmd(5'h15, 8'h0F, 16'd0, 3, ea);
      ws = exp_ws(ea, 0, DIV);
      observe(200);
      checks++;
      if (ob_ws != ws || ob_wcnt != DIV) begin
         errors++;
         $display("FAIL single_window: start=%0d len=%0d required start=%0d len=%0d",
                  ob_ws, ob_wcnt, ws, DIV);
      end
      checks++;
      if (ob_a !== 16'h4015 || ob_d !== 8'h0F) begin
         errors++;
         $display("FAIL single_bus: A=%h D=%h required 4015 0F", ob_a, ob_d);
      end
      checks++;
      if (ob_oe_bad != 0 || ob_busy_bad != 0 || ob_ready_bad != 0) begin
         errors++;
         $display("FAIL single_ctrl: oe_bad=%0d busy_bad=%0d ready_bad=%0d required 0 0 0",
                  ob_oe_bad, ob_busy_bad, ob_ready_bad);
      end
      checks++;
      if (ob_done_e != ws + DIV || ob_done_cnt != 1 || ob_ready_at_done !== 1'b1) begin
         errors++;
         $display("FAIL single_done: edge=%0d pulses=%0d rdy=%b required edge=%0d pulses=1 rdy=1",
                  ob_done_e, ob_done_cnt, ob_ready_at_done, ws + DIV);
      end
   endtask

   task automatic test_delay;
      int ea, ws;
      send_cmd(5'h00, 8'hBF, 16'd3, -1, ea);
      checks++;
      if (A !== 16'h4015 || RnW !== 1'b1) begin
         errors++;
         $display("FAIL idle_hold: A=%h rnw=%b required 4015 1", A, RnW);
      end
      ws = exp_ws(ea, 3, DIV);
      observe(400);
      checks++;
      if (ob_ws != ws || ob_wcnt != DIV || ob_a !== 16'h4000 || ob_d !== 8'hBF) begin
         errors++;
         $display("FAIL delay_write: start=%0d len=%0d A=%h D=%h required %0d %0d 4000 BF",
                  ob_ws, ob_wcnt, ob_a, ob_d, ws, DIV);
      end
      checks++;
      if (ob_done_e != ws + DIV || ob_done_cnt != 1 || ob_busy_bad != 0) begin
         errors++;
         $display("FAIL delay_done: edge=%0d pulses=%0d busy_bad=%0d required %0d 1 0",
                  ob_done_e, ob_done_cnt, ob_busy_bad, ws + DIV);
      end
   endtask

   task automatic test_back_to_back;
      int ea1, ws1, ws2, done1;
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1) begin ok = 1; break; end
      end
      cmd_addr = 5'h0A; cmd_data = 8'h11; cmd_wait = '0; cmd_valid = 1'b1;
      @(posedge CLK);
      #1;
      ea1 = ecnt;
      cmd_addr = 5'h0B; cmd_data = 8'h22;
      ws1   = exp_ws(ea1, 0, DIV);
      done1 = ws1 + DIV;
      observe(200);
      cmd_valid = 1'b0;
      checks++;
      if (!ok || ob_ws != ws1 || ob_wcnt != DIV || ob_a !== 16'h400A || ob_ready_bad != 0) begin
         errors++;
         $display("FAIL b2b_first: start=%0d len=%0d A=%h ready_bad=%0d required %0d %0d 400A 0",
                  ob_ws, ob_wcnt, ob_a, ob_ready_bad, ws1, DIV);
      end
      ws2 = exp_ws(done1 + 1, 0, DIV);
      observe(200);
      checks++;
      if (ob_ws != ws2 || ob_wcnt != DIV || ob_a !== 16'h400B || ob_d !== 8'h22) begin
         errors++;
         $display("FAIL b2b_second: start=%0d len=%0d A=%h D=%h required %0d %0d 400B 22",
                  ob_ws, ob_wcnt, ob_a, ob_d, ws2, DIV);
      end
      checks++;
      if (ob_ws - done1 < DIV) begin
         errors++;
         $display("FAIL b2b_gap: idle clks=%0d required >= %0d", ob_ws - done1, DIV);
      end
   endtask

   task automatic test_reset_mid_write;
      int ea, ws;
      int dn = 0;
      bit ok = 0;
      send_cmd(5'h03, 8'h55, 16'd0, -1, ea);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (RnW === 1'b0 && (ecnt % DIV) == 6) begin ok = 1; break; end
      end
      RES = 1'b1;
      #1;
      checks++;
      if (!ok || {RnW, D_oe, M2, wr_done, busy, cmd_ready} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_mid_write: rnw/oe/m2/done/busy/rdy got %b required 100000",
                  {RnW, D_oe, M2, wr_done, busy, cmd_ready});
      end
      repeat (3) begin
         @(negedge CLK);
         if (wr_done !== 1'b0) dn++;
      end
      RES = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         if (wr_done !== 1'b0) dn++;
      end
      checks++;
      if (dn != 0) begin
         errors++;
         $display("FAIL reset_no_done: pulses got %0d required 0", dn);
      end
      send_cmd(5'h1F, 8'hA5, 16'd1, -1, ea);
      ws = exp_ws(ea, 1, DIV);
      observe(300);
      checks++;
      if (ob_ws != ws || ob_a !== 16'h401F || ob_d !== 8'hA5 || ob_done_e != ws + DIV) begin
         errors++;
         $display("FAIL after_reset_1f: start=%0d A=%h D=%h done=%0d required %0d 401F A5 %0d",
                  ob_ws, ob_a, ob_d, ob_done_e, ws, ws + DIV);
      end
   endtask

   task automatic test_random;
      int ea, ws, w;
      logic [4:0] a;
      logic [7:0] d;
      for (int n = 0; n < 8; n++) begin
         a = 5'($urandom_range(0, 31));
         d = 8'($urandom);
         w = $urandom_range(0, 4);
         repeat ($urandom_range(0, 15)) @(negedge CLK);
         send_cmd(a, d, 16'(w), -1, ea);
         ws = exp_ws(ea, w, DIV);
         observe(600);
         checks++;
         if (ob_ws != ws || ob_wcnt != DIV || ob_a !== {11'h200, a} || ob_d !== d) begin
            errors++;
            $display("FAIL rand_write[%0d]: start=%0d len=%0d A=%h D=%h required %0d %0d %h %h",
                     n, ob_ws, ob_wcnt, ob_a, ob_d, ws, DIV, {11'h200, a}, d);
         end
         checks++;
         if (ob_done_e != ws + DIV || ob_done_cnt != 1 || ob_oe_bad != 0) begin
            errors++;
            $display("FAIL rand_done[%0d]: edge=%0d pulses=%0d oe_bad=%0d required %0d 1 0",
                     n, ob_done_e, ob_done_cnt, ob_oe_bad, ws + DIV);
         end
      end
   endtask

   task automatic test_max_wait;
      int ea, ws, s = -1, de = -1;
      logic [15:0] sa = '0;
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (ready2 === 1'b1) begin ok = 1; break; end
      end
      addr2 = 5'h1F; data2 = 8'h3C; wait2 = '1; v2 = 1'b1;
      @(posedge CLK);
      #1;
      ea = ecnt;
      v2 = 1'b0;
      ws = exp_ws(ea, (1 << WAIT_W2) - 1, DIV2);
      for (int i = 0; i < 20000; i++) begin
         @(negedge CLK);
         if (rnw2 === 1'b0 && s < 0) begin s = ecnt; sa = a2; end
         if (done2 === 1'b1) begin de = ecnt; break; end
      end
      checks++;
      if (!ok || s != ws || sa !== 16'h401F) begin
         errors++;
         $display("FAIL max_wait_write: start=%0d A=%h required %0d 401F", s, sa, ws);
      end
      checks++;
      if (de != ws + DIV2) begin
         errors++;
         $display("FAIL max_wait_done: edge=%0d required %0d", de, ws + DIV2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_delay();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      test_max_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
